// File: rtl/redmule_tcdm_responder.sv
// Shared, word-interleaved TCDM SRAM model for MP narrow ports. It has a
// configurable read latency and a deterministic per-port grant-stall pattern.
module redmule_tcdm_responder #(
   parameter int unsigned MP        = 4,
   parameter int unsigned MEMDW     = 32,
   parameter int unsigned DEPTH     = 4096,
   parameter int unsigned LATENCY   = 1,
   parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic [7:0]                     stall_period_i,
   input  logic [MP-1:0]                  tcdm_req_i,
   output logic [MP-1:0]                  tcdm_gnt_o,
   input  logic [MP-1:0][31:0]            tcdm_add_i,
   input  logic [MP-1:0]                  tcdm_wen_i,
   input  logic [MP-1:0][MEMDW/8-1:0]     tcdm_be_i,
   input  logic [MP-1:0][MEMDW-1:0]       tcdm_data_i,
   output logic [MP-1:0][MEMDW-1:0]       tcdm_r_data_o,
   output logic [MP-1:0]                  tcdm_r_valid_o,
   output logic                           err_o,
   input  logic                           clear_err_i
);

   localparam int unsigned      AW       = $clog2(DEPTH);
   localparam logic [32:0]      SPAN     = 33'(DEPTH) << 2;
   localparam logic [MEMDW-1:0] OOR_DATA = MEMDW'(32'hDEAD_BEEF);

   logic [7:0]                            cnt_q, cnt_d;
   logic                                  err_q, err_d;
   logic [LATENCY-1:0][MP-1:0]            vld_q, vld_d;
   logic [LATENCY-1:0][MP-1:0][MEMDW-1:0] dat_q, dat_d;

   logic [8:0]                            period_p1;
   logic [MP-1:0]                         stall, hs, oor;
   logic [MP-1:0][31:0]                   off;
   logic [MP-1:0][AW-1:0]                 widx;
   logic [MP-1:0][MEMDW-1:0]              rd_data;

   logic [MEMDW-1:0]                      mem [DEPTH];

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can leave it unassigned and infer a latch.
      period_p1  = {1'b0, stall_period_i} + 9'd1;
      stall      = '0;
      hs         = '0;
      oor        = '0;
      off        = '0;
      widx       = '0;
      rd_data    = '0;
      tcdm_gnt_o = '0;

      // Counter wraps 0..period, and wraps early if the period shrinks below it.
      if (stall_period_i == 8'd0 || cnt_q >= stall_period_i) cnt_d = 8'd0;
      else                                                   cnt_d = cnt_q + 8'd1;

      for (int p = 0; p < MP; p++) begin
         stall[p] = (stall_period_i != 8'd0) && ({1'b0, cnt_q} == (9'(p) % period_p1));
         off[p]   = tcdm_add_i[p] - BASE_ADDR;
         oor[p]   = (tcdm_add_i[p] < BASE_ADDR) || ({1'b0, off[p]} >= SPAN);
         widx[p]  = off[p][AW+1:2];
         // Grant is suppressed while reset is asserted so nothing handshakes in reset.
         tcdm_gnt_o[p] = rst_ni && tcdm_req_i[p] && !stall[p];
         hs[p]         = tcdm_gnt_o[p];
         if (hs[p] && tcdm_wen_i[p]) rd_data[p] = oor[p] ? OOR_DATA : mem[widx[p]];
      end

      if (|(hs & oor))      err_d = 1'b1;
      else if (clear_err_i) err_d = 1'b0;
      else                  err_d = err_q;

      vld_d    = '0;
      dat_d    = '0;
      vld_d[0] = hs;
      dat_d[0] = rd_data;
      for (int s = 1; s < LATENCY; s++) begin
         vld_d[s] = vld_q[s-1];
         dat_d[s] = dat_q[s-1];
      end
   end

   // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         err_q <= 1'b0;
         vld_q <= '0;
         dat_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
         vld_q <= vld_d;
         dat_q <= dat_d;
      end
   end

   // NOTE: the array has no reset so its contents survive rst_ni. Later ports
   // overwrite earlier ones, so the highest-index writer wins per byte.
   always_ff @(posedge clk_i) begin
      for (int p = 0; p < MP; p++) begin
         if (hs[p] && !tcdm_wen_i[p] && !oor[p]) begin
            for (int b = 0; b < MEMDW/8; b++) begin
               if (tcdm_be_i[p][b]) mem[widx[p]][8*b +: 8] <= tcdm_data_i[p][8*b +: 8];
            end
         end
      end
   end

   assign tcdm_r_valid_o = vld_q[LATENCY-1];
   assign tcdm_r_data_o  = dat_q[LATENCY-1];
   assign err_o          = err_q;

endmodule

// File: tb/tb_redmule_tcdm_responder.sv
// Bench for redmule_tcdm_responder: directed tables and corner sequences plus
// randomized traffic against a transaction-level model, on latencies 1, 3 and 4.
module tb_redmule_tcdm_responder;

   localparam int          MP    = 4;
   localparam int          DEPTH = 4096;
   localparam logic [31:0] BASE  = 32'h1000_0000;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [7:0]           period;
   logic [MP-1:0]        req, wen;
   logic [MP-1:0][31:0]  add, wdata;
   logic [MP-1:0][3:0]   be;
   logic                 clear_err;

   logic [MP-1:0]        gnt1, gnt3, gnt4, rv1, rv3, rv4;
   logic [MP-1:0][31:0]  rd1, rd3, rd4;
   logic                 err1, err3, err4;

   always #5 clk = ~clk;

   redmule_tcdm_responder #(.MP(MP), .DEPTH(DEPTH), .LATENCY(1), .BASE_ADDR(BASE)) u_l1 (
      .clk_i(clk), .rst_ni(rst_n), .stall_period_i(period), .tcdm_req_i(req), .tcdm_gnt_o(gnt1),
      .tcdm_add_i(add), .tcdm_wen_i(wen), .tcdm_be_i(be), .tcdm_data_i(wdata),
      .tcdm_r_data_o(rd1), .tcdm_r_valid_o(rv1), .err_o(err1), .clear_err_i(clear_err));
   redmule_tcdm_responder #(.MP(MP), .DEPTH(DEPTH), .LATENCY(3), .BASE_ADDR(BASE)) u_l3 (
      .clk_i(clk), .rst_ni(rst_n), .stall_period_i(period), .tcdm_req_i(req), .tcdm_gnt_o(gnt3),
      .tcdm_add_i(add), .tcdm_wen_i(wen), .tcdm_be_i(be), .tcdm_data_i(wdata),
      .tcdm_r_data_o(rd3), .tcdm_r_valid_o(rv3), .err_o(err3), .clear_err_i(clear_err));
   redmule_tcdm_responder #(.MP(MP), .DEPTH(DEPTH), .LATENCY(4), .BASE_ADDR(BASE)) u_l4 (
      .clk_i(clk), .rst_ni(rst_n), .stall_period_i(period), .tcdm_req_i(req), .tcdm_gnt_o(gnt4),
      .tcdm_add_i(add), .tcdm_wen_i(wen), .tcdm_be_i(be), .tcdm_data_i(wdata),
      .tcdm_r_data_o(rd4), .tcdm_r_valid_o(rv4), .err_o(err4), .clear_err_i(clear_err));

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state.
   logic [31:0]         mm [DEPTH];
   logic [MP-1:0]       ring_v [16];
   logic [MP-1:0][31:0] ring_d [16];
   logic                err_m;
   int                  cyc;
   int                  kk;

   // Samples taken at the most recent negedge.
   logic [MP-1:0]       s_gnt1, s_rv1, s_rv3, s_rv4;
   logic [MP-1:0][31:0] s_rd1;
   logic                s_err1;
   bit                  rec;
   int                  qc[$];
   logic [31:0]         qd[$];

   typedef struct {
      logic        rd;
      logic [31:0] a;
      logic [3:0]  b;
      logic [31:0] d;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;
   vec_t tbl[12];

   task automatic check(string name, logic [127:0] act, logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit in_range(logic [31:0] a);
      longint x = longint'({32'h0, a});
      longint b = longint'({32'h0, BASE});
      return (x >= b) && ((x - b) < longint'(DEPTH) * 4);
   endfunction

   function automatic int word_of(logic [31:0] a);
      return int'((a - BASE) >> 2) % DEPTH;
   endfunction

   function automatic bit stalled(int p);
      int m = int'(period) + 1;
      return (period != 8'd0) && ((kk % m) == (p % m));
   endfunction

   task automatic check_dut(string nm, int lat, logic [MP-1:0] g, logic [MP-1:0] rv,
                            logic [MP-1:0][31:0] rd, logic er, logic [MP-1:0] eg);
      logic [MP-1:0]       ev;
      logic [MP-1:0][31:0] ed;
      ev = rst_n ? ring_v[(cyc + 16 - lat) % 16] : '0;
      ed = rst_n ? ring_d[(cyc + 16 - lat) % 16] : '0;
      check({nm, "_gnt"},    128'(g),  128'(eg));
      check({nm, "_rvalid"}, 128'(rv), 128'(ev));
      check({nm, "_rdata"},  128'(rd), 128'(ed));
      check({nm, "_err"},    128'(er), 128'(rst_n ? err_m : 1'b0));
   endtask

   task automatic step();
      logic [MP-1:0]       eg, nv;
      logic [MP-1:0][31:0] nd;
      bit                  any_oor;
      @(negedge clk);
      for (int p = 0; p < MP; p++) eg[p] = rst_n && req[p] && !stalled(p);
      check_dut("l1", 1, gnt1, rv1, rd1, err1, eg);
      check_dut("l3", 3, gnt3, rv3, rd3, err3, eg);
      check_dut("l4", 4, gnt4, rv4, rd4, err4, eg);
      s_gnt1 = gnt1; s_rv1 = rv1; s_rd1 = rd1; s_err1 = err1; s_rv3 = rv3; s_rv4 = rv4;
      if (rec && rv4[2]) begin
         qc.push_back(cyc);
         qd.push_back(rd4[2]);
      end
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) begin
            ring_v[i] = '0;
            ring_d[i] = '0;
         end
         err_m = 1'b0;
         kk    = 0;
      end else begin
         nv = '0; nd = '0; any_oor = 0;
         for (int p = 0; p < MP; p++) begin
            if (eg[p]) begin
               nv[p] = 1'b1;
               if (!in_range(add[p])) begin
                  any_oor = 1;
                  if (wen[p]) nd[p] = 32'hDEAD_BEEF;
               end else if (wen[p]) begin
                  nd[p] = mm[word_of(add[p])];
               end
            end
         end
         for (int p = 0; p < MP; p++) begin
            if (eg[p] && !wen[p] && in_range(add[p])) begin
               for (int b = 0; b < 4; b++)
                  if (be[p][b]) mm[word_of(add[p])][8*b +: 8] = wdata[p][8*b +: 8];
            end
         end
         ring_v[cyc % 16] = nv;
         ring_d[cyc % 16] = nd;
         if (any_oor)        err_m = 1'b1;
         else if (clear_err) err_m = 1'b0;
         kk = (period == 8'd0) ? 0 : kk + 1;
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(int p, logic rd, logic [31:0] a, logic [3:0] b, logic [31:0] d);
      req[p] = 1'b1; wen[p] = rd; add[p] = a; be[p] = b; wdata[p] = d;
   endtask

   // One access on port p followed by an idle cycle; the L=1 response is then in s_*.
   task automatic op(int p, logic rd, logic [31:0] a, logic [3:0] b, logic [31:0] d);
      req = '0;
      drive(p, rd, a, b, d);
      step();
      req = '0;
      step();
   endtask

   task automatic idle(int n);
      req = '0;
      clear_err = 1'b0;
      repeat (n) step();
   endtask

   task automatic do_reset(logic [7:0] per);
      req = '0;
      rst_n = 1'b0;
      period = per;
      step();
      step();
      rst_n = 1'b1;
   endtask

   function automatic logic [31:0] rand_addr();
      if ($urandom_range(0, 9) == 0)
         return ($urandom_range(0, 1) == 1) ? BASE - 32'(4 * $urandom_range(1, 4))
                                             : BASE + 32'(DEPTH * 4) + 32'(4 * $urandom_range(0, 3));
      return BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
   endfunction

   initial begin
      int          den[MP];
      int          and_cnt, multi, first_cyc;
      logic        rv_seen;
      logic [31:0] w_exp;

      rst_n = 1'b0; period = '0; req = '0; wen = '0; add = '0; wdata = '0; be = '0;
      clear_err = 1'b0; err_m = 1'b0; cyc = 0; kk = 0; rec = 0;
      for (int i = 0; i < 16; i++) begin
         ring_v[i] = '0;
         ring_d[i] = '0;
      end

      tbl[0]  = '{1'b0, BASE + 32'h10, 4'hF, 32'hA5A5_1234, 32'h0,         1'b0};
      tbl[1]  = '{1'b1, BASE + 32'h10, 4'hF, 32'h0,         32'hA5A5_1234, 1'b0};
      tbl[2]  = '{1'b1, BASE + 32'h13, 4'hF, 32'h0,         32'hA5A5_1234, 1'b0};
      tbl[3]  = '{1'b0, BASE + 32'h20, 4'hF, 32'h0,         32'h0,         1'b0};
      tbl[4]  = '{1'b0, BASE + 32'h20, 4'h5, 32'h1122_3344, 32'h0,         1'b0};
      tbl[5]  = '{1'b1, BASE + 32'h20, 4'hF, 32'h0,         32'h0022_0044, 1'b0};
      tbl[6]  = '{1'b1, BASE - 32'h4,  4'hF, 32'h0,         32'hDEAD_BEEF, 1'b1};
      tbl[7]  = '{1'b0, BASE + 32'(DEPTH * 4), 4'hF, 32'h5555_5555, 32'h0, 1'b1};
      tbl[8]  = '{1'b1, BASE,          4'hF, 32'h0,         32'hB0B0_0000, 1'b1};
      tbl[9]  = '{1'b0, BASE + 32'((DEPTH - 1) * 4), 4'hF, 32'hCAFE_F00D, 32'h0, 1'b1};
      tbl[10] = '{1'b1, BASE + 32'((DEPTH - 1) * 4), 4'hF, 32'h0, 32'hCAFE_F00D, 1'b1};
      tbl[11] = '{1'b1, BASE + 32'h14, 4'hF, 32'h0,         32'hB0B0_0005, 1'b1};

      // Reset state, with every port requesting.
      req = '1;
      wen = '1;
      add = {MP{BASE}};
      step();
      check("reset_gnt", 128'(s_gnt1), 128'(0));
      check("reset_rvalid", 128'(s_rv1), 128'(0));
      check("reset_rdata", 128'(s_rd1), 128'(0));
      check("reset_err", 128'(s_err1), 128'(0));
      do_reset(8'd0);

      // Preload words 0..15 so no later read returns undefined data.
      for (int i = 0; i < 16; i++) begin
         req = '0;
         drive(i % MP, 1'b0, BASE + 32'(4 * i), 4'hF, {16'hB0B0, 16'(i)});
         step();
      end
      idle(5);

      // Directed single-port table.
      foreach (tbl[i]) begin
         op(0, tbl[i].rd, tbl[i].a, tbl[i].b, tbl[i].d);
         check($sformatf("tbl%0d_rvalid", i), 128'(s_rv1[0]), 128'(1));
         check($sformatf("tbl%0d_rdata", i), 128'(s_rd1[0]), 128'(tbl[i].exp_rd));
         check($sformatf("tbl%0d_err", i), 128'(s_err1), 128'(tbl[i].exp_err));
      end

      // Clearing err; then clear together with a new out-of-range access.
      clear_err = 1'b1;
      step();
      clear_err = 1'b0;
      step();
      check("err_cleared", 128'(s_err1), 128'(0));
      drive(1, 1'b1, BASE - 32'h8, 4'hF, 32'h0);
      step();
      clear_err = 1'b1;
      step();
      req = '0;
      clear_err = 1'b0;
      step();
      check("err_set_wins", 128'(s_err1), 128'(1));
      clear_err = 1'b1;
      step();
      clear_err = 1'b0;

      // Byte enables with a same-cycle read of the old value on port 1.
      op(0, 1'b0, BASE + 32'h24, 4'hF, 32'h0);
      req = '0;
      drive(0, 1'b0, BASE + 32'h24, 4'b0101, 32'h1122_3344);
      drive(1, 1'b1, BASE + 32'h24, 4'hF, 32'h0);
      step();
      req = '0;
      step();
      check("rbw_old", 128'(s_rd1[1]), 128'(0));
      check("rbw_valids", 128'(s_rv1), 128'(4'b0011));
      op(1, 1'b1, BASE + 32'h24, 4'hF, 32'h0);
      check("be_merge", 128'(s_rd1[1]), 128'(32'h0022_0044));

      // Same-cycle write/write: the higher port owns the bytes it enables.
      req = '0;
      drive(0, 1'b0, BASE + 32'h28, 4'hF, 32'hAAAA_AAAA);
      drive(3, 1'b0, BASE + 32'h28, 4'b0011, 32'h1234_5678);
      step();
      op(0, 1'b1, BASE + 32'h28, 4'hF, 32'h0);
      check("ww_priority", 128'(s_rd1[0]), 128'(32'hAAAA_5678));

      // Latency 4: eight back-to-back reads on port 2.
      for (int i = 0; i < 8; i++) begin
         req = '0;
         drive(2, 1'b0, BASE + 32'(4 * i), 4'hF, 32'(i * 3));
         step();
      end
      idle(6);
      qc.delete();
      qd.delete();
      rec = 1;
      first_cyc = cyc;
      for (int i = 0; i < 8; i++) begin
         req = '0;
         drive(2, 1'b1, BASE + 32'(4 * i), 4'hF, 32'h0);
         step();
      end
      idle(8);
      rec = 0;
      check("lat_count", 128'(qc.size()), 128'(8));
      if (qc.size() > 0) check("lat_first", 128'(qc[0] - first_cyc), 128'(4));
      for (int i = 0; i < qc.size() && i < 8; i++) begin
         check($sformatf("lat_data%0d", i), 128'(qd[i]), 128'(32'(i * 3)));
         check($sformatf("lat_b2b%0d", i), 128'(qc[i] - qc[0]), 128'(i));
      end

      // Reset one cycle after a read handshake.
      op(0, 1'b0, BASE + 32'h30, 4'hF, 32'h0BAD_F00D);
      req = '0;
      drive(0, 1'b1, BASE + 32'h30, 4'hF, 32'h0);
      step();
      rst_n = 1'b0;
      step();
      check("rst_gnt", 128'(s_gnt1), 128'(0));
      check("rst_rvalid", 128'({s_rv1, s_rv3, s_rv4}), 128'(0));
      step();
      rst_n = 1'b1;
      req = '0;
      rv_seen = 1'b0;
      repeat (6) begin
         step();
         rv_seen = rv_seen | (|s_rv1) | (|s_rv3) | (|s_rv4);
      end
      check("rst_no_stale", 128'(rv_seen), 128'(0));
      op(0, 1'b1, BASE + 32'h30, 4'hF, 32'h0);
      check("rst_mem_kept", 128'(s_rd1[0]), 128'(32'h0BAD_F00D));

      // Grant-stall patterns, all ports requesting continuously.
      for (int k = 0; k < 2; k++) begin
         do_reset(k == 0 ? 8'd3 : 8'd4);
         req = '1;
         wen = '1;
         add = {MP{BASE}};
         for (int p = 0; p < MP; p++) den[p] = 0;
         and_cnt = 0;
         multi = 0;
         repeat (k == 0 ? 12 : 15) begin
            step();
            for (int p = 0; p < MP; p++) if (!s_gnt1[p]) den[p]++;
            if (&s_gnt1) and_cnt++;
            if ($countones(~s_gnt1) > 1) multi++;
         end
         for (int p = 0; p < MP; p++) check($sformatf("stall%0d_den%0d", k, p), 128'(den[p]), 128'(3));
         check($sformatf("stall%0d_and", k), 128'(and_cnt), 128'(k == 0 ? 0 : 3));
         check($sformatf("stall%0d_distinct", k), 128'(multi), 128'(0));
      end

      // Randomized traffic, without and with stalls.
      for (int k = 0; k < 2; k++) begin
         do_reset(k == 0 ? 8'd0 : 8'd2);
         repeat (300) begin
            for (int p = 0; p < MP; p++) begin
               req[p]   = 1'($urandom_range(0, 1));
               wen[p]   = 1'($urandom_range(0, 1));
               add[p]   = rand_addr();
               be[p]    = 4'($urandom_range(0, 15));
               wdata[p] = $urandom;
            end
            clear_err = ($urandom_range(0, 7) == 0);
            step();
         end
         idle(6);
      end

      // A final readback of a word left by the random traffic.
      w_exp = mm[3];
      op(2, 1'b1, BASE + 32'hC, 4'hF, 32'h0);
      check("final_readback", 128'(s_rd1[2]), 128'(w_exp));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
